// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: round-robin AR grant onto one slave port, R burst routed
// back to the granted master until RLAST, with a sticky burst-length error flag.
module axi_rd_arbiter #(
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned LEN_BITS  = 4
) (
  input  logic                 AXI_CLK_i,
  input  logic                 AXI_RST_i,
  input  logic [ID_BITS-1:0]   ARID_M0_i,
  input  logic [ADDR_BITS-1:0] ARADDR_M0_i,
  input  logic [LEN_BITS-1:0]  ARLEN_M0_i,
  input  logic [2:0]           ARSIZE_M0_i,
  input  logic [1:0]           ARBURST_M0_i,
  input  logic                 ARVALID_M0_i,
  output logic                 ARREADY_M0_o,
  output logic [ID_BITS-1:0]   RID_M0_o,
  output logic [DATA_BITS-1:0] RDATA_M0_o,
  output logic [1:0]           RRESP_M0_o,
  output logic                 RLAST_M0_o,
  output logic                 RVALID_M0_o,
  input  logic                 RREADY_M0_i,
  input  logic [ID_BITS-1:0]   ARID_M1_i,
  input  logic [ADDR_BITS-1:0] ARADDR_M1_i,
  input  logic [LEN_BITS-1:0]  ARLEN_M1_i,
  input  logic [2:0]           ARSIZE_M1_i,
  input  logic [1:0]           ARBURST_M1_i,
  input  logic                 ARVALID_M1_i,
  output logic                 ARREADY_M1_o,
  output logic [ID_BITS-1:0]   RID_M1_o,
  output logic [DATA_BITS-1:0] RDATA_M1_o,
  output logic [1:0]           RRESP_M1_o,
  output logic                 RLAST_M1_o,
  output logic                 RVALID_M1_o,
  input  logic                 RREADY_M1_i,
  output logic [ID_BITS:0]     ARID_S_o,
  output logic [ADDR_BITS-1:0] ARADDR_S_o,
  output logic [LEN_BITS-1:0]  ARLEN_S_o,
  output logic [2:0]           ARSIZE_S_o,
  output logic [1:0]           ARBURST_S_o,
  output logic                 ARVALID_S_o,
  input  logic                 ARREADY_S_i,
  input  logic [ID_BITS:0]     RID_S_i,
  input  logic [DATA_BITS-1:0] RDATA_S_i,
  input  logic [1:0]           RRESP_S_i,
  input  logic                 RLAST_S_i,
  input  logic                 RVALID_S_i,
  output logic                 RREADY_S_o,
  output logic                 ERR_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                err_q, err_d;
  logic [LEN_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_BITS-1:0] len_q, len_d;

  // Routing relies on the latched grant, so the slave-side ID MSB is never decoded.
  logic unused_rid_msb;
  assign unused_rid_msb = RID_S_i[ID_BITS];

  assign ERR_o = err_q;

  always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
    if (AXI_RST_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      beat_cnt_q   <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;

    ARREADY_M0_o = 1'b0;
    ARREADY_M1_o = 1'b0;
    ARID_S_o     = '0;
    ARADDR_S_o   = '0;
    ARLEN_S_o    = '0;
    ARSIZE_S_o   = '0;
    ARBURST_S_o  = '0;
    ARVALID_S_o  = 1'b0;
    RREADY_S_o   = 1'b0;
    RID_M0_o     = '0;
    RDATA_M0_o   = '0;
    RRESP_M0_o   = '0;
    RLAST_M0_o   = 1'b0;
    RVALID_M0_o  = 1'b0;
    RID_M1_o     = '0;
    RDATA_M1_o   = '0;
    RRESP_M1_o   = '0;
    RLAST_M1_o   = 1'b0;
    RVALID_M1_o  = 1'b0;

    case (state_q)
      IDLE: begin
        // Tie goes to the master that did not win last time.
        if (ARVALID_M0_i || ARVALID_M1_i) begin
          grant_d = (ARVALID_M0_i && ARVALID_M1_i) ? ~last_grant_q : ARVALID_M1_i;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (grant_q) begin
          ARID_S_o     = {1'b1, ARID_M1_i};
          ARADDR_S_o   = ARADDR_M1_i;
          ARLEN_S_o    = ARLEN_M1_i;
          ARSIZE_S_o   = ARSIZE_M1_i;
          ARBURST_S_o  = ARBURST_M1_i;
          ARVALID_S_o  = ARVALID_M1_i;
          ARREADY_M1_o = ARREADY_S_i;
        end else begin
          ARID_S_o     = {1'b0, ARID_M0_i};
          ARADDR_S_o   = ARADDR_M0_i;
          ARLEN_S_o    = ARLEN_M0_i;
          ARSIZE_S_o   = ARSIZE_M0_i;
          ARBURST_S_o  = ARBURST_M0_i;
          ARVALID_S_o  = ARVALID_M0_i;
          ARREADY_M0_o = ARREADY_S_i;
        end
        if (ARVALID_S_o && ARREADY_S_i) begin
          len_d      = ARLEN_S_o;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end

      DATA: begin
        RREADY_S_o = grant_q ? RREADY_M1_i : RREADY_M0_i;
        if (grant_q) begin
          RID_M1_o    = RID_S_i[ID_BITS-1:0];
          RDATA_M1_o  = RDATA_S_i;
          RRESP_M1_o  = RRESP_S_i;
          RLAST_M1_o  = RLAST_S_i;
          RVALID_M1_o = RVALID_S_i;
        end else begin
          RID_M0_o    = RID_S_i[ID_BITS-1:0];
          RDATA_M0_o  = RDATA_S_i;
          RRESP_M0_o  = RRESP_S_i;
          RLAST_M0_o  = RLAST_S_i;
          RVALID_M0_o = RVALID_S_i;
        end
        // RLAST must coincide exactly with the final beat of the requested length.
        if (RVALID_S_i && RREADY_S_o) begin
          beat_cnt_d = beat_cnt_q + LEN_BITS'(1);
          if (RLAST_S_i != (beat_cnt_q == len_q)) begin
            err_d = 1'b1;
          end
          if (RLAST_S_i) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: bench-side slave model pushes each R beat to a scoreboard,
// which is popped and compared when the granted master completes the handshake.
module tb_axi_rd_arbiter;
  localparam int unsigned ID_BITS   = 4;
  localparam int unsigned ADDR_BITS = 32;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned LEN_BITS  = 4;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 last;
    logic [ID_BITS-1:0]   id;
    logic [1:0]           resp;
  } rbeat_t;

  logic clk = 1'b0;
  logic rst;
  logic [ID_BITS-1:0]   ARID_M0_i, ARID_M1_i, RID_M0_o, RID_M1_o;
  logic [ADDR_BITS-1:0] ARADDR_M0_i, ARADDR_M1_i, ARADDR_S_o;
  logic [LEN_BITS-1:0]  ARLEN_M0_i, ARLEN_M1_i, ARLEN_S_o;
  logic [2:0]           ARSIZE_M0_i, ARSIZE_M1_i, ARSIZE_S_o;
  logic [1:0]           ARBURST_M0_i, ARBURST_M1_i, ARBURST_S_o;
  logic                 ARVALID_M0_i, ARVALID_M1_i, ARREADY_M0_o, ARREADY_M1_o;
  logic [DATA_BITS-1:0] RDATA_M0_o, RDATA_M1_o, RDATA_S_i;
  logic [1:0]           RRESP_M0_o, RRESP_M1_o, RRESP_S_i;
  logic                 RLAST_M0_o, RLAST_M1_o, RVALID_M0_o, RVALID_M1_o;
  logic                 RREADY_M0_i, RREADY_M1_i;
  logic [ID_BITS:0]     ARID_S_o, RID_S_i;
  logic                 ARVALID_S_o, ARREADY_S_i;
  logic                 RLAST_S_i, RVALID_S_i, RREADY_S_o, ERR_o;

  int total = 0;
  int bad = 0;
  rbeat_t sb[$];

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)
  ) dut (
    .AXI_CLK_i(clk), .AXI_RST_i(rst),
    .ARID_M0_i(ARID_M0_i), .ARADDR_M0_i(ARADDR_M0_i), .ARLEN_M0_i(ARLEN_M0_i),
    .ARSIZE_M0_i(ARSIZE_M0_i), .ARBURST_M0_i(ARBURST_M0_i), .ARVALID_M0_i(ARVALID_M0_i),
    .ARREADY_M0_o(ARREADY_M0_o), .RID_M0_o(RID_M0_o), .RDATA_M0_o(RDATA_M0_o),
    .RRESP_M0_o(RRESP_M0_o), .RLAST_M0_o(RLAST_M0_o), .RVALID_M0_o(RVALID_M0_o),
    .RREADY_M0_i(RREADY_M0_i),
    .ARID_M1_i(ARID_M1_i), .ARADDR_M1_i(ARADDR_M1_i), .ARLEN_M1_i(ARLEN_M1_i),
    .ARSIZE_M1_i(ARSIZE_M1_i), .ARBURST_M1_i(ARBURST_M1_i), .ARVALID_M1_i(ARVALID_M1_i),
    .ARREADY_M1_o(ARREADY_M1_o), .RID_M1_o(RID_M1_o), .RDATA_M1_o(RDATA_M1_o),
    .RRESP_M1_o(RRESP_M1_o), .RLAST_M1_o(RLAST_M1_o), .RVALID_M1_o(RVALID_M1_o),
    .RREADY_M1_i(RREADY_M1_i),
    .ARID_S_o(ARID_S_o), .ARADDR_S_o(ARADDR_S_o), .ARLEN_S_o(ARLEN_S_o),
    .ARSIZE_S_o(ARSIZE_S_o), .ARBURST_S_o(ARBURST_S_o), .ARVALID_S_o(ARVALID_S_o),
    .ARREADY_S_i(ARREADY_S_i), .RID_S_i(RID_S_i), .RDATA_S_i(RDATA_S_i),
    .RRESP_S_i(RRESP_S_i), .RLAST_S_i(RLAST_S_i), .RVALID_S_i(RVALID_S_i),
    .RREADY_S_o(RREADY_S_o), .ERR_o(ERR_o)
  );

  // Master m raises an AR request; size/burst differ per master to expose mis-routing.
  task automatic req(input bit m, input logic [ID_BITS-1:0] id,
                     input logic [ADDR_BITS-1:0] addr, input logic [LEN_BITS-1:0] len);
    if (m) begin
      ARID_M1_i = id; ARADDR_M1_i = addr; ARLEN_M1_i = len;
      ARSIZE_M1_i = 3'd2; ARBURST_M1_i = 2'd1; ARVALID_M1_i = 1'b1;
    end else begin
      ARID_M0_i = id; ARADDR_M0_i = addr; ARLEN_M0_i = len;
      ARSIZE_M0_i = 3'd1; ARBURST_M0_i = 2'd2; ARVALID_M0_i = 1'b1;
    end
  endtask

  // Slave-side model for one burst expected on master m.
  task automatic serve(input bit m, input logic [ID_BITS-1:0] id,
                       input logic [ADDR_BITS-1:0] addr, input logic [LEN_BITS-1:0] len,
                       input int beats, input int stall_at, input int stall_len,
                       input bit keep, input bit drop_all, input bit exp_err);
    bit found = 1'b0;
    bit presented = 1'b0;
    bit rr;
    int i = 0;
    int cyc = 0;
    rbeat_t cur, exp_b;
    sb.delete();
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #1;
      if (ARVALID_S_o === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL ar_timeout: got ARVALID_S_o=%b want 1 for m%0d", ARVALID_S_o, m);
      return;
    end
    total++;
    if (ARID_S_o !== {m, id}) begin
      bad++; $display("FAIL ar_id: got %h want %h", ARID_S_o, {m, id});
    end
    total++;
    if (ARADDR_S_o !== addr || ARLEN_S_o !== len) begin
      bad++; $display("FAIL ar_addr_len: got %h/%0d want %h/%0d", ARADDR_S_o, ARLEN_S_o, addr, len);
    end
    total++;
    if (ARSIZE_S_o !== (m ? 3'd2 : 3'd1) || ARBURST_S_o !== (m ? 2'd1 : 2'd2)) begin
      bad++; $display("FAIL ar_size_burst: got %0d/%0d for m%0d", ARSIZE_S_o, ARBURST_S_o, m);
    end
    total++;
    if ({ARREADY_M1_o, ARREADY_M0_o} !== (m ? 2'b10 : 2'b01)) begin
      bad++; $display("FAIL ar_ready: got %b%b want m%0d only", ARREADY_M1_o, ARREADY_M0_o, m);
    end

    while (i < beats && cyc < 100) begin
      @(negedge clk);
      if (cyc == 0 && !keep) begin
        if (m) ARVALID_M1_i = 1'b0; else ARVALID_M0_i = 1'b0;
      end
      if (!presented) begin
        cur.data = DATA_BITS'($urandom);
        cur.last = (i == beats - 1);
        cur.id   = id;
        cur.resp = 2'(i);
        RID_S_i = {m, id}; RDATA_S_i = cur.data; RLAST_S_i = cur.last;
        RRESP_S_i = cur.resp; RVALID_S_i = 1'b1;
        sb.push_back(cur);
        presented = 1'b1;
      end
      rr = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (m) begin RREADY_M1_i = rr; RREADY_M0_i = 1'b1; end
      else   begin RREADY_M0_i = rr; RREADY_M1_i = 1'b1; end
      #1;
      total++;
      if (RREADY_S_o !== rr) begin
        bad++; $display("FAIL rready_s: cyc %0d got %b want %b", cyc, RREADY_S_o, rr);
      end
      total++;
      if ((m ? RVALID_M0_o : RVALID_M1_o) !== 1'b0 || (m ? RDATA_M0_o : RDATA_M1_o) !== '0) begin
        bad++; $display("FAIL other_master: cyc %0d non-granted sees valid/data for m%0d", cyc, m);
      end
      total++;
      if ((m ? RVALID_M1_o : RVALID_M0_o) !== 1'b1) begin
        bad++; $display("FAIL rvalid_m: cyc %0d got %b want 1", cyc, m ? RVALID_M1_o : RVALID_M0_o);
      end else if (rr) begin
        exp_b = sb.pop_front();
        total++;
        if ((m ? RDATA_M1_o : RDATA_M0_o) !== exp_b.data || (m ? RLAST_M1_o : RLAST_M0_o) !== exp_b.last ||
            (m ? RID_M1_o : RID_M0_o) !== exp_b.id || (m ? RRESP_M1_o : RRESP_M0_o) !== exp_b.resp) begin
          bad++;
          $display("FAIL r_beat%0d: got d=%h l=%b id=%h r=%0d want d=%h l=%b id=%h r=%0d", i,
                   m ? RDATA_M1_o : RDATA_M0_o, m ? RLAST_M1_o : RLAST_M0_o,
                   m ? RID_M1_o : RID_M0_o, m ? RRESP_M1_o : RRESP_M0_o,
                   exp_b.data, exp_b.last, exp_b.id, exp_b.resp);
        end
        i++;
        presented = 1'b0;
      end
      cyc++;
    end

    @(negedge clk);
    RVALID_S_i = 1'b0; RLAST_S_i = 1'b0;
    if (drop_all) begin ARVALID_M0_i = 1'b0; ARVALID_M1_i = 1'b0; end
    #1;
    total++;
    if (i != beats || sb.size() != 0) begin
      bad++; $display("FAIL r_count: got %0d beats (%0d pending) want %0d", i, sb.size(), beats);
    end
    total++;
    if (ERR_o !== exp_err) begin
      bad++; $display("FAIL err: got %b want %b", ERR_o, exp_err);
    end
    total++;
    if (ARVALID_S_o !== 1'b0 || ARREADY_M0_o !== 1'b0 || ARREADY_M1_o !== 1'b0) begin
      bad++; $display("FAIL idle_gap: got ARVALID_S_o=%b ARREADY=%b%b want 0", ARVALID_S_o, ARREADY_M1_o, ARREADY_M0_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ARVALID_M0_i = 1'b1;
    #1;
    total++;
    if (ARVALID_S_o !== 1'b0 || ARREADY_M0_o !== 1'b0 || ARREADY_M1_o !== 1'b0 || RREADY_S_o !== 1'b0) begin
      bad++; $display("FAIL reset_handshake: got arv_s=%b arr=%b%b rr_s=%b want 0", ARVALID_S_o, ARREADY_M1_o, ARREADY_M0_o, RREADY_S_o);
    end
    total++;
    if (RVALID_M0_o !== 1'b0 || RVALID_M1_o !== 1'b0 || ERR_o !== 1'b0 || ARID_S_o !== '0 || ARADDR_S_o !== '0) begin
      bad++; $display("FAIL reset_outputs: got rv=%b%b err=%b arid=%h araddr=%h want 0", RVALID_M1_o, RVALID_M0_o, ERR_o, ARID_S_o, ARADDR_S_o);
    end
    ARVALID_M0_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req(1'b0, 4'h5, 32'h1000, 4'd3);
    #1;
    total++;
    if (ARVALID_S_o !== 1'b0 || ARREADY_M0_o !== 1'b0) begin
      bad++; $display("FAIL ar_latency: got ARVALID_S_o=%b ARREADY_M0_o=%b in request cycle want 0", ARVALID_S_o, ARREADY_M0_o);
    end
    serve(1'b0, 4'h5, 32'h1000, 4'd3, 4, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req(1'b0, 4'h3, 32'h2000, 4'd0);
    req(1'b1, 4'hA, 32'h3000, 4'd0);
    serve(1'b0, 4'h3, 32'h2000, 4'd0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    serve(1'b1, 4'hA, 32'h3000, 4'd0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_alternate();
    req(1'b0, 4'h1, 32'h4000, 4'd1);
    req(1'b1, 4'h2, 32'h5000, 4'd1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) serve(1'b0, 4'h1, 32'h4000, 4'd1, 2, 0, 0, 1'b1, k == 3, 1'b0);
      else            serve(1'b1, 4'h2, 32'h5000, 4'd1, 2, 0, 0, 1'b1, k == 3, 1'b0);
    end
  endtask

  task automatic test_stall();
    req(1'b1, 4'h7, 32'h6000, 4'd3);
    serve(1'b1, 4'h7, 32'h6000, 4'd3, 4, 1, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_err();
    req(1'b0, 4'h9, 32'h7000, 4'd2);
    serve(1'b0, 4'h9, 32'h7000, 4'd2, 2, 0, 0, 1'b0, 1'b0, 1'b1);
    req(1'b1, 4'hB, 32'h8000, 4'd1);
    serve(1'b1, 4'hB, 32'h8000, 4'd1, 2, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    @(negedge clk);
    req(1'b0, 4'h4, 32'h9000, 4'd3);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #1;
      if (ARVALID_S_o === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rmid_ar: got ARVALID_S_o=%b want 1", ARVALID_S_o);
    end
    @(negedge clk);
    ARVALID_M0_i = 1'b0;
    RID_S_i = {1'b0, 4'h4}; RDATA_S_i = 32'hDEAD_0001; RLAST_S_i = 1'b0; RRESP_S_i = 2'd0;
    RVALID_S_i = 1'b1; RREADY_M0_i = 1'b1;
    #1;
    total++;
    if (RVALID_M0_o !== 1'b1 || RDATA_M0_o !== 32'hDEAD_0001) begin
      bad++; $display("FAIL rmid_beat0: got v=%b d=%h want 1/dead0001", RVALID_M0_o, RDATA_M0_o);
    end
    @(negedge clk);
    RDATA_S_i = 32'hDEAD_0002;
    rst = 1'b1;
    #1;
    total++;
    if (RVALID_M0_o !== 1'b0 || RREADY_S_o !== 1'b0 || ARVALID_S_o !== 1'b0 || RDATA_M0_o !== '0) begin
      bad++; $display("FAIL rmid_valids: got rv=%b rr_s=%b arv_s=%b d=%h want 0", RVALID_M0_o, RREADY_S_o, ARVALID_S_o, RDATA_M0_o);
    end
    total++;
    if (ERR_o !== 1'b0) begin
      bad++; $display("FAIL rmid_err: got %b want 0", ERR_o);
    end
    @(negedge clk);
    RVALID_S_i = 1'b0;
    rst = 1'b0;
    req(1'b1, 4'hC, 32'hA000, 4'd1);
    serve(1'b1, 4'hC, 32'hA000, 4'd1, 2, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ARID_M0_i = '0; ARADDR_M0_i = '0; ARLEN_M0_i = '0; ARSIZE_M0_i = '0; ARBURST_M0_i = '0; ARVALID_M0_i = 1'b0;
    ARID_M1_i = '0; ARADDR_M1_i = '0; ARLEN_M1_i = '0; ARSIZE_M1_i = '0; ARBURST_M1_i = '0; ARVALID_M1_i = 1'b0;
    RREADY_M0_i = 1'b0; RREADY_M1_i = 1'b0;
    ARREADY_S_i = 1'b1;
    RID_S_i = '0; RDATA_S_i = '0; RRESP_S_i = '0; RLAST_S_i = 1'b0; RVALID_S_i = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_stall();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
